pipe_adder: RTL and testbench

PIPE_ADDER -- requirements
Module: pipe_adder

---
 rtl/pipe_adder_pkg.sv | 18 +
 rtl/adder_seg.sv | 18 +
 rtl/pipe_adder.sv | 136 +++++++++++++
 tb/tb_pipe_adder.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_adder_pkg.sv
// Shared types for the segmented pipelined adder: operation encoding and result flags.
package pipe_adder_pkg;

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_ADC = 2'b01,
        OP_SUB = 2'b10,
        OP_SBC = 2'b11
    } op_e;

    typedef struct packed {
        logic n;
        logic z;
        logic c;
        logic v;
    } flags_t;

endpackage

// File: rtl/adder_seg.sv
// One pipeline segment: SEG_W-bit add with carry-in, producing sum, carry-out and a zero bit.
module adder_seg
    import pipe_adder_pkg::*;
#(
    parameter int unsigned SEG_W = 8
) (
    input  logic [SEG_W-1:0] a_i,
    input  logic [SEG_W-1:0] b_i,
    input  logic             c_i,
    output logic [SEG_W-1:0] s_o,
    output logic             c_o,
    output logic             z_o
);

    assign {c_o, s_o} = {1'b0, a_i} + {1'b0, b_i} + {{SEG_W{1'b0}}, c_i};
    assign z_o        = (s_o == '0);

endmodule

// File: rtl/pipe_adder.sv
// Pipelined ADD/ADC/SUB/SBC unit: WIDTH/SEG_W stages, one segment per stage, global stall
// on output backpressure, {N,Z,C,V} flags with ARM carry convention.
module pipe_adder
    import pipe_adder_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned SEG_W = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [1:0]       op,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] y,
    output logic [3:0]       flags
);

    localparam int unsigned NSEG = WIDTH / SEG_W;
    localparam logic [WIDTH-1:0] SEG_ONES = WIDTH'({SEG_W{1'b1}});

    if (WIDTH % SEG_W != 0) begin : g_width_check
        $error("pipe_adder: WIDTH must be an integer multiple of SEG_W");
    end

    op_e              op_sel;
    logic [WIDTH-1:0] b_eff;
    logic             cin_eff;
    logic             advance;

    logic [NSEG-1:0]            vld_q, vld_d, c_q, c_d, z_q, z_d;
    logic [NSEG-1:0][WIDTH-1:0] opa_q, opa_d, opb_q, opb_d, res_q, res_d;
    flags_t                     flags_c;
    logic                       unused_fwd;

    assign op_sel = op_e'(op);

    always_comb begin
        b_eff   = b;
        cin_eff = 1'b0;
        unique case (op_sel)
            OP_ADD: cin_eff = 1'b0;
            OP_ADC: cin_eff = cin;
            OP_SUB: begin
                b_eff   = ~b;
                cin_eff = 1'b1;
            end
            OP_SBC: begin
                b_eff   = ~b;
                cin_eff = cin;
            end
        endcase
    end

    // Stage k consumes segment k; operands and the partial result ride along whole so
    // later stages can pick their segment and the last stage can form V from the MSBs.
    for (genvar k = 0; k < NSEG; k++) begin : g_stage
        logic [WIDTH-1:0] a_in, b_in, r_in;
        logic             c_in, z_in, v_in;
        logic [SEG_W-1:0] seg_s;
        logic             seg_z;

        if (k == 0) begin : g_first
            assign a_in = a;
            assign b_in = b_eff;
            assign r_in = '0;
            assign c_in = cin_eff;
            assign z_in = 1'b1;
            assign v_in = in_valid;
        end else begin : g_next
            assign a_in = opa_q[k-1];
            assign b_in = opb_q[k-1];
            assign r_in = res_q[k-1];
            assign c_in = c_q[k-1];
            assign z_in = z_q[k-1];
            assign v_in = vld_q[k-1];
        end

        adder_seg #(.SEG_W(SEG_W)) u_seg (
            .a_i (a_in[k*SEG_W +: SEG_W]),
            .b_i (b_in[k*SEG_W +: SEG_W]),
            .c_i (c_in),
            .s_o (seg_s),
            .c_o (c_d[k]),
            .z_o (seg_z)
        );

        assign opa_d[k] = a_in;
        assign opb_d[k] = b_in;
        assign z_d[k]   = z_in & seg_z;
        assign vld_d[k] = v_in;
        assign res_d[k] = (r_in & ~(SEG_ONES << (k*SEG_W))) | (WIDTH'(seg_s) << (k*SEG_W));
    end

    assign advance   = !vld_q[NSEG-1] || out_ready;
    assign in_ready  = advance;
    assign out_valid = vld_q[NSEG-1];
    assign y         = res_q[NSEG-1];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vld_q <= '0;
            c_q   <= '0;
            z_q   <= '0;
            opa_q <= '0;
            opb_q <= '0;
            res_q <= '0;
        end else if (advance) begin
            vld_q <= vld_d;
            c_q   <= c_d;
            z_q   <= z_d;
            opa_q <= opa_d;
            opb_q <= opb_d;
            res_q <= res_d;
        end
    end

    // Flags derive from final-stage registers, so reset leaves them all 0.
    always_comb begin
        flags_c.n = res_q[NSEG-1][WIDTH-1];
        flags_c.z = z_q[NSEG-1];
        flags_c.c = c_q[NSEG-1];
        flags_c.v = (opa_q[NSEG-1][WIDTH-1] == opb_q[NSEG-1][WIDTH-1]) &&
                    (res_q[NSEG-1][WIDTH-1] != opa_q[NSEG-1][WIDTH-1]);
    end

    assign flags = flags_c;

    // Only operand MSBs are live in the final stage.
    assign unused_fwd = ^{opa_q[NSEG-1][WIDTH-2:0], opb_q[NSEG-1][WIDTH-2:0]};

endmodule

// File: tb/tb_pipe_adder.sv
// Scoreboard bench for pipe_adder (WIDTH=32, SEG_W=8): directed vectors, burst, stall,
// reset-in-flight and a randomised handshake pass checked against a reference model.
module tb_pipe_adder;
    import pipe_adder_pkg::*;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic [1:0]  op = 2'b00;
    logic        cin = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] y;
    logic [3:0]  flags;

    pipe_adder #(.WIDTH(32), .SEG_W(8)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .op        (op),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .y         (y),
        .flags     (flags)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] y;
        logic [3:0]  f;
        int unsigned acc;
        bit          lat;
    } exp_t;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [1:0]  op;
        logic        cin;
        logic [31:0] y;
        logic [3:0]  f;
    } vec_t;

    exp_t        exp_q[$];
    int unsigned ncmp = 0;
    int unsigned nfail = 0;
    int unsigned cyc = 0;
    int unsigned streak = 0;
    int unsigned max_streak = 0;
    bit          rnd_rdy = 1'b0;

    // a, b, op, cin, expected y, expected {N,Z,C,V}
    vec_t dir_v [11] = '{
        '{32'hFFFFFFFF, 32'h00000001, 2'b00, 1'b0, 32'h00000000, 4'b0110},
        '{32'h80000000, 32'h00000001, 2'b10, 1'b0, 32'h7FFFFFFF, 4'b0011},
        '{32'h00000005, 32'h00000007, 2'b11, 1'b1, 32'hFFFFFFFE, 4'b1000},
        '{32'h7FFFFFFF, 32'h00000001, 2'b00, 1'b0, 32'h80000000, 4'b1001},
        '{32'h00000005, 32'h00000005, 2'b11, 1'b0, 32'hFFFFFFFF, 4'b1000},
        '{32'h00000005, 32'h00000005, 2'b10, 1'b0, 32'h00000000, 4'b0110},
        '{32'h000000FF, 32'h00000001, 2'b01, 1'b1, 32'h00000101, 4'b0000},
        '{32'h00000001, 32'h00000001, 2'b00, 1'b1, 32'h00000002, 4'b0000},
        '{32'h0000000A, 32'h00000003, 2'b10, 1'b0, 32'h00000007, 4'b0010},
        '{32'h00FFFF00, 32'h00000100, 2'b00, 1'b0, 32'h01000000, 4'b0000},
        '{32'h80000000, 32'h80000000, 2'b00, 1'b0, 32'h00000000, 4'b0111}
    };

    // ADC 0xFFFFFFFF + b + cin with (b,cin) = (0,0),(0,1),(1,0),(1,1),(2,0),(2,1),(3,0),(3,1)
    logic [31:0] burst_y [8] = '{32'hFFFFFFFF, 32'h0, 32'h0, 32'h1, 32'h1, 32'h2, 32'h2, 32'h3};
    logic [3:0]  burst_f [8] = '{4'b1000, 4'b0110, 4'b0110, 4'b0010,
                                 4'b0010, 4'b0010, 4'b0010, 4'b0010};

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
        ncmp++;
        if (act !== expv) begin
            nfail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, expv, $time);
        end
    endtask

    function automatic logic [35:0] model(input logic [31:0] ma, input logic [31:0] mb,
                                          input logic [1:0] mop, input logic mcin);
        logic [31:0] be;
        logic        ci;
        logic [32:0] s;
        logic [3:0]  f;
        be = mop[1] ? ~mb : mb;
        ci = (mop == 2'b00) ? 1'b0 : (mop == 2'b10) ? 1'b1 : mcin;
        s  = {1'b0, ma} + {1'b0, be} + {32'b0, ci};
        f  = {s[31], s[31:0] == 32'h0, s[32], (ma[31] == be[31]) && (s[31] != ma[31])};
        return {s[31:0], f};
    endfunction

    // Call at a negedge; returns at the negedge after the beat is accepted.
    task automatic send(input logic [31:0] ta, input logic [31:0] tb, input logic [1:0] top,
                        input logic tci, input logic [31:0] ey, input logic [3:0] ef,
                        input bit lat);
        int unsigned guard = 0;
        exp_t        e;
        a = ta; b = tb; op = top; cin = tci; in_valid = 1'b1;
        #1;
        while (!in_ready && guard < 100) begin
            @(negedge clk);
            #1;
            guard++;
        end
        if (!in_ready) begin
            check("accept_timeout", {63'b0, in_ready}, 64'd1);
            in_valid = 1'b0;
            @(negedge clk);
        end else begin
            e.y = ey; e.f = ef; e.acc = cyc; e.lat = lat;
            exp_q.push_back(e);
            @(negedge clk);
            in_valid = 1'b0;
            a = $urandom;
            b = $urandom;
        end
    endtask

    task automatic drain();
        int unsigned g = 0;
        while (exp_q.size() != 0 && g < 300) begin
            @(negedge clk);
            g++;
        end
        check("drain", 64'(exp_q.size()), 64'd0);
        repeat (2) @(negedge clk);
    endtask

    // Monitor: compares whenever a result is presented, pops on handshake.
    initial forever begin
        @(negedge clk);
        #2;
        if (reset_n && out_valid) begin
            if (exp_q.size() == 0) begin
                if (out_ready) check("spurious_out", {63'b0, out_valid}, 64'd0);
            end else begin
                check("result", {28'b0, y, flags}, {28'b0, exp_q[0].y, exp_q[0].f});
                if (out_ready) begin
                    if (exp_q[0].lat) check("latency", 64'(cyc - exp_q[0].acc), 64'd4);
                    exp_q.delete(0);
                end
            end
        end
        if (out_valid && out_ready) begin
            streak++;
            if (streak > max_streak) max_streak = streak;
        end else begin
            streak = 0;
        end
    end

    initial forever begin
        @(negedge clk);
        if (rnd_rdy) out_ready = 1'($urandom_range(0, 1));
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, expected completion");
        $fatal(1);
    end

    initial begin
        logic [35:0] m;
        logic [31:0] ra, rb;
        logic [1:0]  rop;
        logic        rc;

        repeat (3) @(negedge clk);
        #1;
        check("reset_out_valid", {63'b0, out_valid}, 64'd0);
        check("reset_y", {32'b0, y}, 64'd0);
        check("reset_flags", {60'b0, flags}, 64'd0);
        check("reset_in_ready", {63'b0, in_ready}, 64'd1);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 11; i++)
            send(dir_v[i].a, dir_v[i].b, dir_v[i].op, dir_v[i].cin, dir_v[i].y, dir_v[i].f, i == 0);
        drain();

        max_streak = 0;
        for (int i = 0; i < 8; i++)
            send(32'hFFFFFFFF, 32'(i / 2), OP_ADC, 1'(i % 2), burst_y[i], burst_f[i], 1'b0);
        drain();
        check("burst_streak", 64'(max_streak), 64'd8);

        fork
            begin
                for (int i = 1; i <= 6; i++)
                    send(32'(i), 32'h10, OP_ADD, 1'b0, 32'(16 + i), 4'b0000, 1'b0);
            end
            begin
                int unsigned g = 0;
                out_ready = 1'b0;
                #1;
                while (!out_valid && g < 20) begin
                    @(negedge clk);
                    #1;
                    g++;
                end
                check("stall_out_valid", {63'b0, out_valid}, 64'd1);
                check("stall_in_ready", {63'b0, in_ready}, 64'd0);
                repeat (6) @(negedge clk);
                out_ready = 1'b1;
            end
        join
        drain();

        out_ready = 1'b0;
        for (int i = 1; i <= 3; i++)
            send(32'(i), 32'h1, OP_ADD, 1'b0, 32'(i + 1), 4'b0000, 1'b0);
        begin
            int unsigned g = 0;
            while (!out_valid && g < 20) begin
                @(negedge clk);
                g++;
            end
        end
        check("pre_reset_valid", {63'b0, out_valid}, 64'd1);
        #3;
        reset_n = 1'b0;
        #1;
        check("async_rst_out_valid", {63'b0, out_valid}, 64'd0);
        check("async_rst_y", {32'b0, y}, 64'd0);
        check("async_rst_flags", {60'b0, flags}, 64'd0);
        check("async_rst_in_ready", {63'b0, in_ready}, 64'd1);
        exp_q.delete();
        @(negedge clk);
        reset_n = 1'b1;
        out_ready = 1'b1;
        repeat (10) @(negedge clk);
        send(32'h2, 32'h3, OP_ADD, 1'b0, 32'h5, 4'b0000, 1'b1);
        drain();

        rnd_rdy = 1'b1;
        for (int i = 0; i < 40; i++) begin
            ra  = $urandom;
            rb  = (i % 5 == 0) ? ra : $urandom;
            rop = 2'($urandom_range(0, 3));
            rc  = 1'($urandom_range(0, 1));
            m   = model(ra, rb, rop, rc);
            send(ra, rb, rop, rc, m[35:4], m[3:0], 1'b0);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        rnd_rdy = 1'b0;
        #1;
        out_ready = 1'b1;
        @(negedge clk);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule
